inst_fetch_seq: RTL and testbench
=================================

# inst_fetch_seq

Parametrised instruction fetch sequencer: owns a single-port instruction SRAM, loads a program through a write port, then streams instructions to the decoder over a valid/ready handshake at up to one instruction per cycle. Successor to the fixed-width program-counter/memory block. Adds:
- a program load port
- start/done control
- a 2-entry prefetch buffer with backpressure
- one hardware zero-overhead loop (start/end/iteration count)

Sits between the host/config interface and the instruction decoder.

## Interface
- DW, default `FULL_INSTRUCTION_BITWIDTH: instruction width in bits
- DEPTH, default `IMEM_DEPTH: instruction words
- AW, default $clog2(DEPTH): address width
- LCW, default 16: loop iteration counter width
- clk  in  1  clock; everything on posedge
- rst  in  1  synchronous, active-high reset
- load_en  in  1  write load_data to load_addr; honoured only in IDLE
- load_addr  in  AW  program write address
- load_data  in  DW  program write data
- start  in  1  begin execution; honoured only in IDLE
- instruction_count  in  AW+1  program length; sampled at start
- loop_en, loop_start[AW], loop_end[AW], loop_iters[LCW]  in  loop config; sampled at start
- inst  out  DW  instruction at buffer head
- inst_pc  out  AW  address of inst
- inst_valid  out  1  head valid
- inst_ready  in  1  decoder accepts head
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on program completion
- loop_cfg_err  out  1  sticky: loop config rejected at last start; cleared by next accepted start

## Operation
**States: IDLE, RUN, DRAIN**

- **IDLE**
  - Loads allowed.
  - On start:
    - If instruction_count == 0: pulse done next cycle, stay IDLE.
    - Otherwise: latch config, go to RUN.
    - instruction_count > DEPTH is clamped to DEPTH.
- **RUN**
  - Issue one SRAM read per cycle at fetch_pc while credit allows.
  - fetch_pc next value:
    - If loop active and fetch_pc == loop_end and iter_left > 0: next = loop_start, iter_left -= 1.
    - Else: next = fetch_pc + 1.
  - After issuing address count-1 (with no loop-back pending): go to DRAIN.
- **DRAIN**
  - No new reads.
  - When outstanding == 0 and buffer empty: go to IDLE, pulse done.
- **Loop rules**
  - loop_iters = extra passes; 0 means the body executes once.
  - Loop is rejected (treated as disabled, loop_cfg_err set) when loop_start > loop_end or loop_end >= count.
  - Hence loop_en with iters N executes the body N+1 times.
- **Credit**
  - Issue allowed when occ + outstanding − pop < 2.
  - outstanding ∈ {0,1}; pop = inst_valid & inst_ready.
- **Buffer**
  - 2-entry FIFO of {inst, pc}.
  - SRAM q is written the cycle after issue.
  - Head is registered.
- **Ignored inputs**
  - start/load_en while busy: ignored, no side effects.
  - load_en and start in the same IDLE cycle: the load happens; start uses pre-load contents only if the read address differs. Otherwise the load wins and the read returns new data (write-first).
- **Reset mid-operation**
  - State → IDLE, FIFO flushed, counters cleared, loop_cfg_err = 0.
  - SRAM contents retained.
- **Reset values:** inst = 0, inst_pc = 0, inst_valid = 0, busy = 0, done = 0, loop_cfg_err = 0.

## Timing
- start accepted in cycle T → RUN at T+1 (read addr 0) → q at T+2 → inst_valid at T+3.
- Startup latency is 3 cycles.
- With inst_ready held high: one instruction per cycle, no bubbles, including across loop-back.
- inst_ready low: at most 2 instructions buffered; issue stalls without loss or duplication.
- inst/inst_pc remain stable while inst_valid & !inst_ready.
- done asserts the cycle after the final pop; busy deasserts in the same cycle as done.
- Loads are single-cycle SRAM writes; there is no read-during-load within a run.

## Structure
- Shared package (defines.sv):
  - instruction_t
  - `IMEM_DEPTH, `FULL_INSTRUCTION_BITWIDTH
  - fetch state enum typedef
- Memory: existing `array` sub-module.
  - cen active low; wen/gwen low = write.
  - Address muxed between load_addr (IDLE) and fetch_pc.
- Sub-module: fetch_skid_fifo (2-entry, parametrised width DW+AW).
  - Reusable for other streaming memories.

## Test plan
- Load 8 words (data = 0x100+addr), count = 8, no loop, ready high → pcs 0..7 on consecutive cycles, first valid at T+3, done one cycle after the last pop.
- Same program, ready toggling 1,0,0,1 → exact 0..7 sequence, no drops or duplicates, inst stable while stalled.
- count = 6, loop_en, start = 1, end = 3, iters = 2 → pc sequence 0,1,2,3,1,2,3,1,2,3,4,5; no bubbles with ready high.
- loop_start = 4, loop_end = 2 → loop_cfg_err = 1, linear 0..count-1 executed; next valid start clears the flag.
- count = 0 → done pulse, no inst_valid; count = DEPTH+5 → clamped, exactly DEPTH instructions.
- rst asserted while 2 entries are buffered → next cycle: inst_valid = 0, busy = 0; re-start replays from pc 0 with the original SRAM contents.
- start/load_en while busy → no effect.

Source files
------------

// File: rtl/inst_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: default memory
// geometry, the instruction word type and the fetch FSM state encoding.
package inst_fetch_seq_pkg;

  localparam int IMEM_DEPTH                = 16;
  localparam int FULL_INSTRUCTION_BITWIDTH = 32;

  typedef logic [FULL_INSTRUCTION_BITWIDTH-1:0] instruction_t;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

endpackage : inst_fetch_seq_pkg

// File: rtl/inst_fetch_seq_skid_fifo.sv
// Two-entry FIFO with a registered head, used to absorb the one-cycle SRAM
// read latency and decoder backpressure. Generic width so any streaming
// memory front-end can reuse it.
module fetch_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop;

  assign pop = pop_i && (count_q != 2'd0);

  // Next-state: head always holds the oldest entry; tail only when two are held.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push_i) begin
          head_d  = push_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push_i && pop) begin
          head_d = push_data_i;
        end else if (push_i) begin
          tail_d  = push_data_i;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push_i) tail_d = push_data_i;
          else        count_d = 2'd1;
        end
      end
    endcase
  end

  // State register with synchronous flush.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule : fetch_skid_fifo

// File: rtl/inst_fetch_seq.sv
// Instruction fetch sequencer: owns the single-port instruction SRAM, accepts
// program loads while idle, then streams {instruction, pc} to the decoder at
// up to one per cycle with one hardware zero-overhead loop.
module inst_fetch_seq
  import inst_fetch_seq_pkg::*;
#(
  parameter int DW    = FULL_INSTRUCTION_BITWIDTH,
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int LCW   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_en,
  input  logic [AW-1:0]  load_addr,
  input  logic [DW-1:0]  load_data,
  input  logic           start,
  input  logic [AW:0]    instruction_count,
  input  logic           loop_en,
  input  logic [AW-1:0]  loop_start,
  input  logic [AW-1:0]  loop_end,
  input  logic [LCW-1:0] loop_iters,
  output logic [DW-1:0]  inst,
  output logic [AW-1:0]  inst_pc,
  output logic           inst_valid,
  input  logic           inst_ready,
  output logic           busy,
  output logic           done,
  output logic           loop_cfg_err
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  fetch_state_e   state_q, state_d;
  logic [AW-1:0]  fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]  last_pc_q;
  logic [AW-1:0]  loop_start_q, loop_end_q;
  logic [LCW-1:0] iter_left_q, iter_left_d;
  logic           loop_active_q;
  logic           rvalid_q;
  logic [AW-1:0]  rpc_q;
  logic [DW-1:0]  mem_q;
  logic           done_q;
  logic           loop_cfg_err_q;

  logic [AW:0]    count_clamped;
  logic           loop_cfg_ok;
  logic           start_ok, start_run, start_empty;
  logic           pop, credit_ok, issue, loop_back, last_issue, drain_done;
  logic [1:0]     fifo_count;
  logic           mem_cen_n, mem_wen_n;
  logic [AW-1:0]  mem_addr;

  logic [DW-1:0]  mem [DEPTH];

  // Start qualification, loop config check, credit and loop-back decisions.
  always_comb begin
    count_clamped = (instruction_count > DEPTH_W) ? DEPTH_W : instruction_count;
    loop_cfg_ok   = (loop_start <= loop_end) && ({1'b0, loop_end} < count_clamped);
    start_ok      = (state_q == FETCH_IDLE) && start;
    start_run     = start_ok && (instruction_count != '0);
    start_empty   = start_ok && (instruction_count == '0);
    pop           = inst_valid && inst_ready;
    // Entries held after this cycle plus the read in flight must leave room.
    credit_ok     = ({1'b0, fifo_count} + {2'b00, rvalid_q} - {2'b00, pop}) < 3'd2;
    issue         = (state_q == FETCH_RUN) && credit_ok;
    loop_back     = loop_active_q && (fetch_pc_q == loop_end_q) && (iter_left_q != '0);
    last_issue    = issue && !loop_back && (fetch_pc_q == last_pc_q);
    // FIFO empty once this cycle's pop completes and nothing is in flight.
    drain_done    = !rvalid_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));
    fetch_pc_d    = fetch_pc_q;
    iter_left_d   = iter_left_q;
    if (issue) begin
      if (loop_back) begin
        fetch_pc_d  = loop_start_q;
        iter_left_d = iter_left_q - LCW'(1);
      end else begin
        fetch_pc_d  = fetch_pc_q + AW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE:  if (start_run)  state_d = FETCH_RUN;
      FETCH_RUN:   if (last_issue) state_d = FETCH_DRAIN;
      FETCH_DRAIN: if (drain_done) state_d = FETCH_IDLE;
      default:                     state_d = FETCH_IDLE;
    endcase
  end

  // FSM outputs: status and SRAM port control (address muxed by state).
  always_comb begin
    busy      = (state_q != FETCH_IDLE);
    mem_wen_n = !((state_q == FETCH_IDLE) && load_en);
    mem_cen_n = mem_wen_n && !issue;
    mem_addr  = (state_q == FETCH_IDLE) ? load_addr : fetch_pc_q;
  end

  // Run configuration, fetch pointer, read tracking and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q     <= '0;
      last_pc_q      <= '0;
      loop_start_q   <= '0;
      loop_end_q     <= '0;
      iter_left_q    <= '0;
      loop_active_q  <= 1'b0;
      rvalid_q       <= 1'b0;
      rpc_q          <= '0;
      done_q         <= 1'b0;
      loop_cfg_err_q <= 1'b0;
    end else begin
      done_q   <= start_empty || ((state_q == FETCH_DRAIN) && drain_done);
      rvalid_q <= issue;
      if (issue) rpc_q <= fetch_pc_q;
      if (start_run) begin
        fetch_pc_q     <= '0;
        last_pc_q      <= AW'(count_clamped - (AW+1)'(1));
        loop_start_q   <= loop_start;
        loop_end_q     <= loop_end;
        iter_left_q    <= loop_iters;
        loop_active_q  <= loop_en && loop_cfg_ok;
        loop_cfg_err_q <= loop_en && !loop_cfg_ok;
      end else begin
        fetch_pc_q  <= fetch_pc_d;
        iter_left_q <= iter_left_d;
      end
    end
  end

  // Single-port instruction SRAM, write-first on a load cycle.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset so program contents survive rst.
    if (!mem_cen_n) begin
      if (!mem_wen_n) begin
        mem[mem_addr] <= load_data;
        mem_q         <= load_data;
      end else begin
        mem_q <= mem[mem_addr];
      end
    end
  end

  fetch_skid_fifo #(
    .W (DW + AW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rvalid_q),
    .push_data_i ({mem_q, rpc_q}),
    .pop_i       (pop),
    .head_o      ({inst, inst_pc}),
    .valid_o     (inst_valid),
    .count_o     (fifo_count)
  );

  assign done         = done_q;
  assign loop_cfg_err = loop_cfg_err_q;

endmodule : inst_fetch_seq

// File: tb/tb_inst_fetch_seq.sv
// Directed bench for inst_fetch_seq: loads a program, runs linear, stalled,
// looped, rejected-loop, empty, clamped and reset-interrupted sequences and
// compares every popped {pc, instruction} against a bench-side memory model.
module tb_inst_fetch_seq;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LCW   = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_en;
  logic [AW-1:0]  load_addr;
  logic [DW-1:0]  load_data;
  logic           start;
  logic [AW:0]    instruction_count;
  logic           loop_en;
  logic [AW-1:0]  loop_start;
  logic [AW-1:0]  loop_end;
  logic [LCW-1:0] loop_iters;
  logic [DW-1:0]  inst;
  logic [AW-1:0]  inst_pc;
  logic           inst_valid;
  logic           inst_ready;
  logic           busy;
  logic           done;
  logic           loop_cfg_err;

  inst_fetch_seq #(
    .DW (DW), .DEPTH (DEPTH), .AW (AW), .LCW (LCW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .load_en           (load_en),
    .load_addr         (load_addr),
    .load_data         (load_data),
    .start             (start),
    .instruction_count (instruction_count),
    .loop_en           (loop_en),
    .loop_start        (loop_start),
    .loop_end          (loop_end),
    .loop_iters        (loop_iters),
    .inst              (inst),
    .inst_pc           (inst_pc),
    .inst_valid        (inst_valid),
    .inst_ready        (inst_ready),
    .busy              (busy),
    .done              (done),
    .loop_cfg_err      (loop_cfg_err)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] model_mem [DEPTH];
  int            exp_pc [64];
  int            exp_len;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int a, input logic [DW-1:0] d);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    tick();
    load_en      = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic expect_linear(input int n);
    for (int i = 0; i < n; i++) exp_pc[i] = i;
    exp_len = n;
  endtask

  // Start a run and consume it; toggle selects the 1,0,0,1 ready pattern,
  // poke drives start/load_en into the busy sequencer mid-run.
  task automatic run_prog(input string name, input int cnt, input bit lp, input int ls,
                          input int le, input int li, input bit toggle, input bit poke);
    int            popped      = 0;
    int            first_valid = -1;
    int            done_cyc    = -1;
    int            last_pop    = -1;
    int            bubbles     = 0;
    int            stab_err    = 0;
    int            cyc;
    bit            held        = 1'b0;
    bit            rdy;
    logic [DW-1:0] h_inst      = '0;
    logic [AW-1:0] h_pc        = '0;
    instruction_count = (AW+1)'(cnt);
    loop_en    = lp;
    loop_start = AW'(ls);
    loop_end   = AW'(le);
    loop_iters = LCW'(li);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    check({name, " busy after start"}, busy, 1);
    while (cyc < 300 && done_cyc < 0) begin
      if (held && (!inst_valid || inst !== h_inst || inst_pc !== h_pc)) stab_err++;
      if (inst_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cyc = cyc;
        check({name, " busy low with done"}, busy, 0);
        check({name, " valid low with done"}, inst_valid, 0);
      end else begin
        rdy = toggle ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
        inst_ready = rdy;
        if (poke && cyc == 5) begin
          start             = 1'b1;
          load_en           = 1'b1;
          load_addr         = AW'(2);
          load_data         = 32'hDEAD_BEEF;
          instruction_count = (AW+1)'(3);
        end
        if (inst_valid && rdy) begin
          if (popped < exp_len) begin
            check($sformatf("%s pc[%0d]", name, popped), inst_pc, exp_pc[popped]);
            check($sformatf("%s inst[%0d]", name, popped), inst, model_mem[exp_pc[popped]]);
          end
          if (!toggle && last_pop >= 0 && cyc != last_pop + 1) bubbles++;
          last_pop = cyc;
          popped++;
        end
        held   = inst_valid && !rdy;
        h_inst = inst;
        h_pc   = inst_pc;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        cyc++;
      end
    end
    inst_ready = 1'b1;
    check({name, " done seen"}, (done_cyc >= 0), 1);
    check({name, " pop count"}, popped, exp_len);
    check({name, " done after last pop"}, done_cyc, last_pop + 1);
    check({name, " head stable when stalled"}, stab_err, 0);
    if (!toggle) begin
      check({name, " first valid latency"}, first_valid, 3);
      check({name, " bubbles"}, bubbles, 0);
    end
    tick();
    check({name, " done is a pulse"}, done, 0);
    check({name, " idle after done"}, busy, 0);
  endtask

  initial begin
    int loop_seq [12] = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 3, 4, 5};
    int leak;
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    instruction_count = '0; loop_en = 1'b0; loop_start = '0; loop_end = '0;
    loop_iters = '0; inst_ready = 1'b1;
    tick();
    tick();
    check("reset inst", inst, 0);
    check("reset inst_pc", inst_pc, 0);
    check("reset inst_valid", inst_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset loop_cfg_err", loop_cfg_err, 0);
    rst = 1'b0;
    tick();

    for (int a = 0; a < 8; a++) load_word(a, DW'(32'h100 + a));

    expect_linear(8);
    run_prog("linear", 8, 0, 0, 0, 0, 0, 0);
    run_prog("stall", 8, 0, 0, 0, 0, 1, 0);
    run_prog("busy_poke", 8, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 12; i++) exp_pc[i] = loop_seq[i];
    exp_len = 12;
    run_prog("loop", 6, 1, 1, 3, 2, 0, 0);
    check("loop cfg accepted", loop_cfg_err, 0);

    expect_linear(8);
    run_prog("bad_loop", 8, 1, 4, 2, 5, 0, 0);
    check("bad loop flagged", loop_cfg_err, 1);
    expect_linear(3);
    run_prog("clear_err", 3, 0, 0, 0, 0, 0, 0);
    check("err cleared by start", loop_cfg_err, 0);

    instruction_count = '0;
    loop_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("count0 done", done, 1);
    check("count0 busy", busy, 0);
    check("count0 valid", inst_valid, 0);
    leak = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (inst_valid || busy || done) leak++;
    end
    check("count0 quiet after", leak, 0);

    for (int a = 8; a < DEPTH; a++) load_word(a, DW'(32'h100 + a));
    expect_linear(DEPTH);
    run_prog("clamp", DEPTH + 5, 0, 0, 0, 0, 0, 0);

    instruction_count = (AW+1)'(8);
    inst_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre-reset head valid", inst_valid, 1);
    check("pre-reset head pc", inst_pc, 0);
    rst = 1'b1;
    tick();
    check("mid reset valid", inst_valid, 0);
    check("mid reset busy", busy, 0);
    check("mid reset inst", inst, 0);
    rst = 1'b0;
    inst_ready = 1'b1;
    tick();
    expect_linear(8);
    run_prog("replay", 8, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_inst_fetch_seq
